// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: ALU entry FSM states, opcode width and operand sign-fill helper.
package cpu_types_pkg;

    localparam int ALUOP_W   = 4;
    localparam int OPERAND_W = 32;

    // Encodings are shown directly on the stage LEDs.
    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        ENTER_OP = 3'd2,
        ISSUE    = 3'd3,
        HOLD     = 3'd4
    } entry_state_t;

    function automatic logic [OPERAND_W-1:0] sign_fill(input logic fill, input logic [15:0] data);
        return {{(OPERAND_W-16){fill}}, data};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability-count debouncer and one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [1:0]       fill_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            fill_q  <= 2'b00;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_i};
            fill_q  <= {fill_q[0], 1'b1};
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    // A key held through reset must first be seen released (after the
    // synchronizer has refilled) before a press can be reported.
    always_comb begin
        db_d    = db_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (fill_q[1] && sync_q[1]) begin
            armed_d = 1'b1;
        end
        if (sync_q[1] != db_q) begin
            if (cnt_q >= CNT_LAST) begin
                db_d  = sync_q[1];
                cnt_d = '0;
            end else begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
        press_d = armed_q & db_q & ~db_d;
    end

    assign press_o = press_q;

endmodule

// File: rtl/alu_entry_ctrl.sv
// Pushbutton-driven operand/opcode entry for an ALU: collects a, b, aluop and issues a go strobe.
module alu_entry_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [3:0]           KEY,
    input  logic [17:0]          SW,
    output logic [OPERAND_W-1:0] a,
    output logic [OPERAND_W-1:0] b,
    output logic [ALUOP_W-1:0]   aluop,
    output logic                 go,
    output logic                 valid,
    output logic [2:0]           stage
);

    entry_state_t         state_q, state_d;
    logic [OPERAND_W-1:0] a_q, a_d;
    logic [OPERAND_W-1:0] b_q, b_d;
    logic [ALUOP_W-1:0]   aluop_q, aluop_d;
    logic                 valid_q, valid_d;
    logic                 enter_ev;
    logic                 clear_ev;
    logic [OPERAND_W-1:0] operand;
    logic                 unused_inputs;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_key (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .key_i  (KEY[0]),
        .press_o(enter_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .key_i  (KEY[1]),
        .press_o(clear_ev)
    );

    assign unused_inputs = ^{KEY[3:2], SW[17]};
    assign operand       = sign_fill(SW[16], SW[15:0]);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            aluop_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            aluop_q <= aluop_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        aluop_d = aluop_q;
        valid_d = valid_q;
        case (state_q)
            // Events landing on the issue cycle are intentionally dropped.
            ISSUE: begin
                valid_d = 1'b1;
                state_d = HOLD;
            end
            default: begin
                if (clear_ev) begin
                    a_d     = '0;
                    b_d     = '0;
                    aluop_d = '0;
                    valid_d = 1'b0;
                    state_d = ENTER_A;
                end else if (enter_ev) begin
                    case (state_q)
                        ENTER_A: begin
                            a_d     = operand;
                            valid_d = 1'b0;
                            state_d = ENTER_B;
                        end
                        ENTER_B: begin
                            b_d     = operand;
                            state_d = ENTER_OP;
                        end
                        ENTER_OP: begin
                            aluop_d = SW[ALUOP_W-1:0];
                            state_d = ISSUE;
                        end
                        default: state_d = ENTER_A;
                    endcase
                end
            end
        endcase
    end

    assign a     = a_q;
    assign b     = b_q;
    assign aluop = aluop_q;
    assign valid = valid_q;
    assign go    = (state_q == ISSUE);
    assign stage = state_q;

endmodule

// File: tb/tb_alu_entry_ctrl.sv
// Self-checking bench for alu_entry_ctrl with a short debounce window and an event-level model.
module tb_alu_entry_ctrl;

    localparam int DB = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [3:0]  KEY = 4'hF;
    logic [17:0] SW = '0;
    logic [31:0] a, b;
    logic [3:0]  aluop;
    logic        go, valid;
    logic [2:0]  stage;

    int checks = 0;
    int failures = 0;

    // Reference model: what the outputs should be after each complete key event.
    logic [31:0] m_a = '0, m_b = '0;
    logic [3:0]  m_op = '0;
    logic        m_valid = 1'b0;
    int          m_stage = 0;
    int          m_go = 0;

    int   go_cnt = 0;
    int   go_consec = 0;
    logic go_prev = 1'b0;

    alu_entry_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .KEY  (KEY),
        .SW   (SW),
        .a    (a),
        .b    (b),
        .aluop(aluop),
        .go   (go),
        .valid(valid),
        .stage(stage)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (go === 1'b1) begin
            go_cnt = go_cnt + 1;
            if (go_prev === 1'b1) go_consec = go_consec + 1;
        end
        go_prev = go;
    end

    function automatic logic [71:0] outs();
        return {a, b, aluop, valid, stage};
    endfunction

    function automatic logic [71:0] exp_outs();
        return {m_a, m_b, m_op, m_valid, 3'(m_stage)};
    endfunction

    task automatic m_reset();
        m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0; m_stage = 0;
    endtask

    task automatic m_enter(input logic [17:0] sw);
        if (m_stage == 0) begin
            m_a = {{16{sw[16]}}, sw[15:0]}; m_valid = 1'b0; m_stage = 1;
        end else if (m_stage == 1) begin
            m_b = {{16{sw[16]}}, sw[15:0]}; m_stage = 2;
        end else if (m_stage == 2) begin
            m_op = sw[3:0]; m_go = m_go + 1; m_valid = 1'b1; m_stage = 4;
        end else begin
            m_stage = 0;
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Press the keys in mask long enough to debounce, then release and settle.
    task automatic press(input logic [3:0] mask, input logic [17:0] sw);
        @(negedge CLK);
        SW  = sw;
        KEY = ~mask;
        wait_neg(10);
        KEY = 4'hF;
        wait_neg(10);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        wait_neg(3);
        checks++;
        if ({outs(), go} !== 73'd0) begin
            failures++;
            $display("FAIL reset_hold: outs=%h go=%b expected all zero", outs(), go);
        end
        nRST = 1'b1;
        m_reset();
        wait_neg(5);
        checks++;
        if ({outs(), go} !== 73'd0) begin
            failures++;
            $display("FAIL reset_release: outs=%h go=%b expected all zero", outs(), go);
        end
    endtask

    task automatic test_sign_fill();
        press(4'b0001, 18'h10005);
        m_enter(18'h10005);
        checks++;
        if (a !== 32'hFFFF0005 || stage !== 3'd1) begin
            failures++;
            $display("FAIL sign_fill: a=%h stage=%0d expected a=ffff0005 stage=1", a, stage);
        end
        checks++;
        if (outs() !== exp_outs()) begin
            failures++;
            $display("FAIL sign_fill_all: outs=%h expected=%h", outs(), exp_outs());
        end
    endtask

    task automatic test_latency();
        int n = 0;
        logic [17:0] sw = 18'(($urandom & 32'h1FFFF));
        @(negedge CLK);
        SW  = sw;
        KEY = 4'b1110;
        while (n < 20 && stage === 3'd1) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n < 2 + DB + 1 - 1 || n > 2 + DB + 1 + 1) begin
            failures++;
            $display("FAIL press_latency: cycles=%0d expected %0d (+/-1)", n, 2 + DB + 1);
        end
        wait_neg(5);
        KEY = 4'hF;
        wait_neg(10);
        m_enter(sw);
        checks++;
        if (outs() !== exp_outs()) begin
            failures++;
            $display("FAIL latency_capture: outs=%h expected=%h", outs(), exp_outs());
        end
    endtask

    task automatic test_glitch();
        @(negedge CLK);
        SW  = 18'(($urandom & 32'h3FFFF));
        KEY = 4'b1110;
        wait_neg(2);
        KEY = 4'hF;
        wait_neg(15);
        checks++;
        if (outs() !== exp_outs()) begin
            failures++;
            $display("FAIL glitch: outs=%h expected=%h", outs(), exp_outs());
        end
    endtask

    task automatic test_full_entry();
        int go_before;
        press(4'b0010, 18'h0);
        m_reset();
        checks++;
        if (outs() !== exp_outs()) begin
            failures++;
            $display("FAIL full_clear: outs=%h expected=%h", outs(), exp_outs());
        end
        press(4'b0001, 18'h00005); m_enter(18'h00005);
        press(4'b0001, 18'h00003); m_enter(18'h00003);
        go_before = go_cnt;
        press(4'b0001, 18'h00002); m_enter(18'h00002);
        checks++;
        if (go_cnt - go_before !== 1 || go_consec !== 0) begin
            failures++;
            $display("FAIL full_go: pulses=%0d consecutive=%0d expected 1 and 0", go_cnt - go_before, go_consec);
        end
        checks++;
        if ({a, b, aluop, valid, stage} !== {32'h5, 32'h3, 4'h2, 1'b1, 3'd4}) begin
            failures++;
            $display("FAIL full_outs: outs=%h expected a=5 b=3 op=2 valid=1 stage=4", outs());
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            SW = 18'($urandom);
            wait_neg(3);
        end
        checks++;
        if (outs() !== exp_outs()) begin
            failures++;
            $display("FAIL hold_sw_change: outs=%h expected=%h", outs(), exp_outs());
        end
    endtask

    task automatic test_clear_priority();
        press(4'b0001, 18'h0ABCD); m_enter(18'h0ABCD);
        press(4'b0001, 18'h1234F); m_enter(18'h1234F);
        checks++;
        if (stage !== 3'd1) begin
            failures++;
            $display("FAIL clear_setup: stage=%0d expected 1", stage);
        end
        press(4'b0011, 18'h0FFFF);
        m_reset();
        checks++;
        if (stage !== 3'd0 || a !== 32'd0 || valid !== 1'b0 || outs() !== exp_outs()) begin
            failures++;
            $display("FAIL clear_priority: outs=%h expected=%h", outs(), exp_outs());
        end
    endtask

    task automatic test_mid_reset();
        press(4'b0001, 18'h00011); m_enter(18'h00011);
        press(4'b0001, 18'h00022); m_enter(18'h00022);
        checks++;
        if (outs() !== exp_outs()) begin
            failures++;
            $display("FAIL midreset_setup: outs=%h expected=%h", outs(), exp_outs());
        end
        @(negedge CLK);
        KEY = 4'b1110;
        #2 nRST = 1'b0;
        #1;
        m_reset();
        checks++;
        if ({outs(), go} !== 73'd0) begin
            failures++;
            $display("FAIL async_reset: outs=%h go=%b expected all zero", outs(), go);
        end
        @(negedge CLK);
        nRST = 1'b1;
        wait_neg(20);
        checks++;
        if (outs() !== exp_outs()) begin
            failures++;
            $display("FAIL held_through_reset: outs=%h expected=%h", outs(), exp_outs());
        end
        KEY = 4'hF;
        wait_neg(10);
        press(4'b0001, 18'h00077); m_enter(18'h00077);
        checks++;
        if (outs() !== exp_outs()) begin
            failures++;
            $display("FAIL repress_after_reset: outs=%h expected=%h", outs(), exp_outs());
        end
    endtask

    task automatic test_random();
        logic [17:0] sw;
        int r;
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            sw = 18'($urandom);
            if (r <= 6) begin
                press(4'b0001, sw);
                m_enter(sw);
            end else if (r == 7) begin
                press(4'b0010, sw);
                m_reset();
            end else if (r == 8) begin
                @(negedge CLK);
                KEY = ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'b1101;
                wait_neg($urandom_range(1, 2));
                KEY = 4'hF;
                wait_neg(10);
            end else begin
                press(4'b1100, sw);
            end
            checks++;
            if (outs() !== exp_outs()) begin
                failures++;
                $display("FAIL random_%0d op=%0d: outs=%h expected=%h", i, r, outs(), exp_outs());
            end
        end
        checks++;
        if (go_cnt !== m_go || go_consec !== 0) begin
            failures++;
            $display("FAIL go_total: pulses=%0d consecutive=%0d expected %0d and 0", go_cnt, go_consec, m_go);
        end
    endtask

    initial begin
        test_reset();
        test_sign_fill();
        test_latency();
        test_glitch();
        test_full_entry();
        test_clear_priority();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
